// File: rtl/control_unit_4bit.sv
// Multi-cycle fetch/decode/execute sequencer for the 4-bit CPU.
// Drives the function-unit control word and register-file addresses and owns the PC.
module control_unit_4bit #(
  parameter int unsigned PC_W     = 6,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [11:0]     imem_data,
  input  logic            imem_valid,
  output logic [1:0]      rf_da,
  output logic [1:0]      rf_aa,
  output logic [1:0]      rf_ba,
  output logic            rf_we,
  output logic            const_en,
  output logic [3:0]      const_val,
  output logic [3:0]      g_select,
  output logic [1:0]      h_select,
  output logic            mf_select,
  input  logic            v,
  input  logic            c,
  input  logic            n,
  input  logic            z,
  output logic [3:0]      status,
  output logic            halted
);

  localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);

  localparam logic [3:0] OpBz  = 4'hD;
  localparam logic [3:0] OpJmp = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StHalt} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [11:0]     ir_q, ir_d;
  logic [3:0]      status_q, status_d;
  logic            imem_rd_q, rf_we_q, halted_q, rf_we_d;

  logic [3:0] g_q, g_dec;
  logic [1:0] h_q, h_dec;
  logic       mf_q, mf_dec;
  logic       ce_q, ce_dec;
  logic [3:0] cv_q, cv_dec;
  logic [1:0] da_q, aa_q, ba_q;

  logic [3:0] op;
  logic       wb_op;
  logic       taken;

  assign op    = ir_q[11:8];
  assign wb_op = (op >= 4'h1) && (op <= 4'hC);
  // BZ tests the status latched by an earlier write-back, not this cycle's flags.
  assign taken = (op == OpJmp) || ((op == OpBz) && status_q[0]);

  // Opcode to control word; unlisted opcodes leave everything at zero.
  always_comb begin
    g_dec  = 4'b0000;
    h_dec  = 2'b00;
    mf_dec = 1'b0;
    ce_dec = 1'b0;
    cv_dec = 4'h0;
    case (op)
      4'h1: g_dec = 4'b0010;
      4'h2: g_dec = 4'b0101;
      4'h3: g_dec = 4'b0001;
      4'h4: g_dec = 4'b0110;
      4'h5: g_dec = 4'b1000;
      4'h6: g_dec = 4'b1001;
      4'h7: g_dec = 4'b1010;
      4'h8: g_dec = 4'b1011;
      4'h9: begin
        mf_dec = 1'b1;
        h_dec  = 2'b01;
      end
      4'hA: begin
        mf_dec = 1'b1;
        h_dec  = 2'b10;
      end
      4'hB: begin
        mf_dec = 1'b1;
        ce_dec = 1'b1;
        cv_dec = ir_q[3:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    status_d = status_q;
    unique case (state_q)
      StIdle: if (start) state_d = StFetch;
      StFetch: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (wb_op) status_d = {v, c, n, z};
        if (taken) pc_d = ir_q[PC_W-1:0];
        state_d = (op == OpHlt) ? StHalt : StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
    rf_we_d = (state_d == StExec) && wb_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= ResetPc;
      ir_q      <= '0;
      status_q  <= '0;
      imem_rd_q <= 1'b0;
      rf_we_q   <= 1'b0;
      halted_q  <= 1'b0;
      g_q       <= '0;
      h_q       <= '0;
      mf_q      <= 1'b0;
      ce_q      <= 1'b0;
      cv_q      <= '0;
      da_q      <= '0;
      aa_q      <= '0;
      ba_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      status_q  <= status_d;
      imem_rd_q <= (state_d == StFetch);
      rf_we_q   <= rf_we_d;
      halted_q  <= (state_d == StHalt);
      // Control outputs change only when leaving DECODE and hold until the next one.
      if (state_q == StDecode) begin
        g_q  <= g_dec;
        h_q  <= h_dec;
        mf_q <= mf_dec;
        ce_q <= ce_dec;
        cv_q <= cv_dec;
        da_q <= ir_q[7:6];
        aa_q <= ir_q[5:4];
        ba_q <= ir_q[3:2];
      end
    end
  end

  assign imem_addr = pc_q;
  assign imem_rd   = imem_rd_q;
  assign rf_we     = rf_we_q;
  assign halted    = halted_q;
  assign status    = status_q;
  assign g_select  = g_q;
  assign h_select  = h_q;
  assign mf_select = mf_q;
  assign const_en  = ce_q;
  assign const_val = cv_q;
  assign rf_da     = da_q;
  assign rf_aa     = aa_q;
  assign rf_ba     = ba_q;

endmodule

// File: doc/control_unit_4bit.md
# control_unit_4bit

Multi-cycle sequencer for the 4-bit CPU that fetches 12-bit instructions, decodes them and drives the function unit's control word (`g_select`, `h_select`, `mf_select`) plus the register-file addresses and write enable. It is the command side of the function unit. It sends the control word, receives the V/C/N/Z flags, latches them into a status register and uses them for conditional branches. It owns the program counter and the instruction-memory fetch handshake.

## Interface
Parameters:
- `PC_W`, default 6, program-counter width. Legal range 1–8.
- `RESET_PC`, default 0, value loaded into the PC on reset.

Ports:
- `clk`  in  1  single clock. Every register updates on the rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `start`  in  1  starts execution when sampled high in IDLE.
- `imem_addr`  out  PC_W  fetch address. Equals the PC.
- `imem_rd`  out  1  fetch request.
- `imem_data`  in  12  instruction word.
- `imem_valid`  in  1  `imem_data` is valid this cycle.
- `rf_da`, `rf_aa`, `rf_ba`  out  2 each  register-file destination, A-source and B-source addresses.
- `rf_we`  out  1  register-file write enable.
- `const_en`  out  1  selects `const_val` onto bus B in place of the register-file B output.
- `const_val`  out  4  immediate value.
- `g_select`  out  4  function-unit ALU select.
- `h_select`  out  2  function-unit shifter select.
- `mf_select`  out  1  function-unit output select: 0 = ALU result, 1 = shifter result.
- `v`, `c`, `n`, `z`  in  1 each  flags from the function unit.
- `status`  out  4  latched flags, packed as {V,C,N,Z}.
- `halted`  out  1  processor has executed HLT.

## Operation
- Instruction fields:
  - `op` = [11:8]
  - `DA` = [7:6]
  - `AA` = [5:4]
  - `BA` = [3:2]
  - `imm` = [3:0]
  - branch/jump target = [PC_W-1:0]
- Opcode → control word. Every entry not listed below is 0.
  - 0 NOP: no control word, no write.
  - 1 ADD: g=0010.
  - 2 SUB: g=0101.
  - 3 INC: g=0001.
  - 4 DEC: g=0110.
  - 5 AND: g=1000.
  - 6 OR: g=1001.
  - 7 XOR: g=1010.
  - 8 NOT: g=1011.
  - 9 SHR: mf=1, h=01.
  - A SHL: mf=1, h=10.
  - B LDI: mf=1, h=00, const_en=1, const_val=imm.
  - C MOV: g=0000.
  - D BZ: taken when `status[0]`=1; no write.
  - E JMP: unconditional; no write.
  - F HLT.
- Write-back opcodes are 1–C. For these, `rf_we` is high and `status` loads {v,c,n,z} at the end of EXEC.
- `status` holds its value for all other opcodes.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
  - IDLE: `start`=1 → FETCH.
  - FETCH: `imem_rd`=1 and `imem_addr`=PC. On `imem_valid`=1: latch IR, set PC←PC+1 (wraps modulo 2^PC_W), go to DECODE. Otherwise stay in FETCH.
  - DECODE: load the control-word, address and constant output registers from IR. Always goes to EXEC.
  - EXEC:
    - `rf_we` is asserted for write-back opcodes.
    - A taken BZ or any JMP sets PC←target.
    - HLT → HALT. Every other opcode → FETCH.
  - HALT: `halted`=1. Stays here until reset; `start` is ignored.
- `imem_valid` is ignored outside FETCH.
- `start` is ignored outside IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - PC = `RESET_PC`.
  - Every other output is 0, including `imem_addr` bits beyond the PC, `status` and `halted`.
  - State = IDLE.
- Minimum of 3 cycles per instruction: FETCH (with `imem_valid` in the same cycle), DECODE, EXEC.
- `imem_rd` is high in every FETCH cycle and low in every other state.
- `imem_addr` stays stable while FETCH waits for `imem_valid`.
- `rf_we` is high for exactly one cycle, during EXEC.
- Control-word, address and constant outputs become valid in the first EXEC cycle. They hold their values until the next DECODE.
- The flags `v`,`c`,`n`,`z` are sampled on the clock edge that ends EXEC.
- A branch taken in EXEC is reflected in `imem_addr` in the immediately following FETCH cycle.
- When `rst_n` is asserted low in any state, all outputs return to reset values immediately and asynchronously, including `rf_we`. No partial write is committed.

## Test plan
- Reset mid-EXEC of an ADD → `rf_we` drops without waiting for a clock edge, and the state is IDLE. After release and `start`=1, the next cycle shows `imem_rd`=1 and `imem_addr`=0.
- Instruction 0x16C with `v`,`c`,`n`,`z` = 0,1,0,1 in EXEC → EXEC shows:
  - `g_select`=0010, `mf_select`=0;
  - `rf_da`=1, `rf_aa`=2, `rf_ba`=3;
  - `rf_we`=1 for one cycle.
  - Then `status`=0101.
- Instruction 0xB89 → EXEC shows `const_en`=1, `const_val`=9, `mf_select`=1, `h_select`=00, `rf_da`=2, `rf_we`=1.
- Fetch stall and wrap:
  - `imem_valid` held low for 5 cycles → `imem_rd` stays 1, `imem_addr` stays stable, `rf_we` stays 0.
  - Fetch at PC=63 (`PC_W`=6) → the next fetch address is 0.
- Branches:
  - `status`=0001 with BZ 0xD25 → next `imem_addr`=0x25.
  - `status`=0000 with the same BZ → next `imem_addr`=PC+1.
  - JMP 0xE3F → next `imem_addr`=0x3F.
- HLT 0xF00 → after EXEC, `halted`=1 and `imem_rd` stays 0 indefinitely. Pulsing `start` has no effect. Only reset clears `halted`.
